// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer constants, pixel type and block-address helper.
// Framebuffer is 160x120 words, one word per 4x4 pixel block.
package vga_pkg;

  localparam int HD       = 640;
  localparam int VD       = 480;
  localparam int HMAX     = 800;
  localparam int VMAX     = 525;

  localparam int FB_W     = 160;
  localparam int FB_WORDS = 19200;
  localparam int DW       = 12;
  localparam int AW       = 15;

  typedef logic [DW-1:0] pixel_t;

  // (y>>2)*160 + (x>>2) as a shift-add: 160 = 128 + 32.
  function automatic logic [AW-1:0] blk_addr(input logic [9:0] px, input logic [9:0] py);
    logic [AW-1:0] xb;
    logic [AW-1:0] yb;
    xb = AW'(px[9:2]);
    yb = AW'(py[9:2]);
    return (yb << 7) + (yb << 5) + xb;
  endfunction

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Writer request channel and single-port video RAM bus of the arbiter.
// slave = arbiter side, master = writer/RAM side.
interface vga_vram_arbiter_if #(
  parameter int DW = 12,
  parameter int AW = 15
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, ram_rdata,
    output wr_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, ram_rdata,
    input  wr_ready, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO for buffered framebuffer writes; head is visible on dout.
// Pointers carry one wrap bit, so full/empty come from pointer compares alone.
module vga_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign dout    = mem_q[rptr_q[PW-1:0]];
  // Full refuses a push even when the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares one video RAM between block scan-out reads and FIFO-buffered game writes.
// Every display output path is 3 cycles behind the x/y sample.
module vga_vram_arbiter #(
  parameter int DW         = 12,
  parameter int AW         = 15,
  parameter int FB_W       = 160,
  parameter int FB_WORDS   = 19200,
  parameter int FIFO_DEPTH = 4,
  parameter int VD         = 480
) (
  input  logic                clk_100MHz,
  input  logic                reset_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                video_on_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  vga_vram_arbiter_if.slave   bus,
  output logic [DW-1:0]       rgb,
  output logic                video_on_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                frame_tick,
  output logic                err_drop
);
  import vga_pkg::*;

  // The display address is a fixed 128+32 shift-add, only valid for 160-wide buffers.
  if (FB_W != 160) begin : g_bad_fb_w
    $error("vga_vram_arbiter: FB_W must be 160");
  end

  logic [AW+DW-1:0] fifo_dout;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             disp_slot;
  logic             in_range;
  logic             tick_now;

  logic          ram_en_q,    ram_en_d;
  logic          ram_we_q,    ram_we_d;
  logic [AW-1:0] ram_addr_q,  ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          rd_vld_q,    rd_vld_d;
  logic [DW-1:0] hold_q,      hold_d;
  logic          err_q,       err_d;
  logic [2:0]    von_q,       von_d;
  logic [2:0]    hs_q,        hs_d;
  logic [2:0]    vs_q,        vs_d;
  logic [2:0]    tick_q,      tick_d;

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW + DW)
  ) u_fifo (
    .clk   (clk_100MHz),
    .rst_n (reset_n),
    .push  (bus.wr_valid),
    .din   ({bus.wr_addr, bus.wr_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_addr    = fifo_dout[AW+DW-1:DW];
  assign head_data    = fifo_dout[DW-1:0];
  assign in_range     = (32'(head_addr) < FB_WORDS);
  assign disp_slot    = video_on_i && (x[1:0] == 2'b00);
  assign fifo_pop     = !disp_slot && !fifo_empty;
  assign tick_now     = (x == 10'd0) && (y == 10'(VD));
  assign bus.wr_ready = !fifo_full;

  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    err_d       = err_q;
    if (disp_slot) begin
      ram_en_d   = 1'b1;
      ram_addr_d = AW'(blk_addr(x, y));
    end else if (fifo_pop) begin
      // Out-of-range entries are consumed without touching the RAM.
      if (in_range) begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = head_addr;
        ram_wdata_d = head_data;
      end else begin
        err_d = 1'b1;
      end
    end

    rd_vld_d = ram_en_q && !ram_we_q;
    hold_d   = rd_vld_q ? bus.ram_rdata : hold_q;
    von_d    = {von_q[1:0], video_on_i};
    hs_d     = {hs_q[1:0], hsync_i};
    vs_d     = {vs_q[1:0], vsync_i};
    tick_d   = {tick_q[1:0], tick_now};
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_vld_q    <= 1'b0;
      hold_q      <= '0;
      err_q       <= 1'b0;
      von_q       <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      tick_q      <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_vld_q    <= rd_vld_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      von_q       <= von_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  assign video_on_o = von_q[2];
  assign hsync_o    = hs_q[2];
  assign vsync_o    = vs_q[2];
  assign frame_tick = tick_q[2];
  assign rgb        = von_q[2] ? hold_q : '0;
  assign err_drop   = err_q;

endmodule
